// File: rtl/axi_slave_read_engine_pkg.sv
// Shared AXI definitions: bus widths, burst and response encodings, and
// small helpers used by the read engine and the address generator.
package axi_slave_read_engine_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest beat this 32-bit slave can serve: 4 bytes
    localparam logic [AXI_SIZE_BITS-1:0] MAX_SIZE = 3'd2;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [AXI_LEN_BITS-1:0] len);
        case (len)
            4'd1, 4'd3, 4'd7, 4'd15: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address arithmetic. Produces the address of the
// beat following 'addr' and the highest beat address reached by a burst that
// starts at 'addr' (33 bits so a 32-bit overflow is visible to the caller).
module axi_burst_addr_gen
    import axi_slave_read_engine_pkg::*;
(
    input  logic [AXI_ADDR_BITS-1:0] addr,
    input  logic [AXI_LEN_BITS-1:0]  len,
    input  logic [AXI_SIZE_BITS-1:0] size,
    input  logic [1:0]               burst,
    output logic [AXI_ADDR_BITS-1:0] next_addr,
    output logic [AXI_ADDR_BITS:0]   hi_addr
);

    logic [AXI_ADDR_BITS-1:0] beat_bytes_s;
    logic [AXI_ADDR_BITS-1:0] total_bytes_s;
    logic [AXI_ADDR_BITS-1:0] len_bytes_s;
    logic [AXI_ADDR_BITS-1:0] wrap_mask_s;
    logic [AXI_ADDR_BITS-1:0] wrap_base_s;
    logic [AXI_ADDR_BITS-1:0] incr_addr_s;

    assign beat_bytes_s  = 32'd1 << size;
    assign len_bytes_s   = AXI_ADDR_BITS'(len) << size;
    assign total_bytes_s = (AXI_ADDR_BITS'(len) + 32'd1) << size;
    assign wrap_mask_s   = total_bytes_s - 32'd1;
    assign wrap_base_s   = addr & ~wrap_mask_s;
    assign incr_addr_s   = addr + beat_bytes_s;

    // Select next-beat and highest-beat address by burst type
    always_comb begin
        next_addr = addr;
        hi_addr   = {1'b0, addr};
        case (burst)
            BURST_FIXED: begin
                next_addr = addr;
                hi_addr   = {1'b0, addr};
            end
            BURST_INCR: begin
                next_addr = incr_addr_s;
                hi_addr   = {1'b0, addr} + {1'b0, len_bytes_s};
            end
            BURST_WRAP: begin
                next_addr = wrap_base_s | (incr_addr_s & wrap_mask_s);
                hi_addr   = {1'b0, wrap_base_s} + {1'b0, total_bytes_s} - {1'b0, beat_bytes_s};
            end
            default: begin
                next_addr = addr;
                hi_addr   = {1'b0, addr};
            end
        endcase
    end

endmodule

// File: rtl/axi_slave_read_engine.sv
// AXI read slave in front of a single-cycle SRAM. One burst at a time:
// each beat issues one SRAM read, waits one cycle for data, then presents
// it on R until the master accepts it. Illegal or out-of-range bursts are
// answered with SLVERR and zero data without touching the SRAM.
module axi_slave_read_engine
    import axi_slave_read_engine_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    output logic [AXI_IDS_BITS-1:0]  RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    output logic                     mem_ce,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    input  logic [AXI_DATA_BITS-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // First byte address past the end of the attached SRAM
    localparam logic [AXI_ADDR_BITS:0] MEM_LIMIT =
        {{(AXI_ADDR_BITS-2){1'b0}}, 3'd4} << MEM_ADDR_BITS;

    state_t                   state_r, state_s;
    logic [AXI_ADDR_BITS-1:0] addr_r,  addr_s;
    logic [AXI_LEN_BITS-1:0]  len_r,   len_s;
    logic [AXI_SIZE_BITS-1:0] size_r,  size_s;
    logic [1:0]               burst_r, burst_s;
    logic [AXI_IDS_BITS-1:0]  id_r,    id_s;
    logic [AXI_LEN_BITS-1:0]  cnt_r,   cnt_s;
    logic                     err_r,   err_s;

    logic [AXI_DATA_BITS-1:0] rdata_r;
    logic                     arready_r;
    logic                     rvalid_r;
    logic                     rlast_r;
    logic [1:0]               rresp_r;
    logic                     mem_ce_r;
    logic [MEM_ADDR_BITS-1:0] mem_addr_r;

    logic [AXI_ADDR_BITS-1:0] gen_addr_s;
    logic [AXI_LEN_BITS-1:0]  gen_len_s;
    logic [AXI_SIZE_BITS-1:0] gen_size_s;
    logic [1:0]               gen_burst_s;
    logic [AXI_ADDR_BITS-1:0] gen_next_s;
    logic [AXI_ADDR_BITS:0]   gen_hi_s;
    logic                     ar_err_s;
    logic                     last_s;

    // Address generator sees the incoming request while idle (range check)
    // and the latched burst otherwise (next-beat address)
    always_comb begin
        if (state_r == ST_IDLE) begin
            gen_addr_s  = ARADDR_S;
            gen_len_s   = ARLEN_S;
            gen_size_s  = ARSIZE_S;
            gen_burst_s = ARBURST_S;
        end else begin
            gen_addr_s  = addr_r;
            gen_len_s   = len_r;
            gen_size_s  = size_r;
            gen_burst_s = burst_r;
        end
    end

    axi_burst_addr_gen u_addr_gen (
        .addr      (gen_addr_s),
        .len       (gen_len_s),
        .size      (gen_size_s),
        .burst     (gen_burst_s),
        .next_addr (gen_next_s),
        .hi_addr   (gen_hi_s)
    );

    assign ar_err_s = (ARBURST_S == BURST_RSVD)
                   || (ARSIZE_S > MAX_SIZE)
                   || ((ARBURST_S == BURST_WRAP) && !wrap_len_ok(ARLEN_S))
                   || ({1'b0, ARADDR_S} >= MEM_LIMIT)
                   || (gen_hi_s >= MEM_LIMIT);

    assign last_s = (cnt_r == len_r);

    // Next-state and burst-context update
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        len_s   = len_r;
        size_s  = size_r;
        burst_s = burst_r;
        id_s    = id_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (ARVALID_S) begin
                    addr_s  = ARADDR_S;
                    len_s   = ARLEN_S;
                    size_s  = ARSIZE_S;
                    burst_s = ARBURST_S;
                    id_s    = ARID_S;
                    cnt_s   = {AXI_LEN_BITS{1'b0}};
                    err_s   = ar_err_s;
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: state_s = ST_WAIT;
            ST_WAIT: state_s = ST_RESP;
            ST_RESP: begin
                if (RREADY_S) begin
                    if (last_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s   = cnt_r + 4'd1;
                        addr_s  = gen_next_s;
                        state_s = ST_ADDR;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and burst-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= 32'd0;
            len_r   <= 4'd0;
            size_r  <= 3'd0;
            burst_r <= 2'd0;
            id_r    <= 8'd0;
            cnt_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            len_r   <= len_s;
            size_r  <= size_s;
            burst_r <= burst_s;
            id_r    <= id_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Registered handshake, response and SRAM strobe outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= 32'd0;
            mem_ce_r   <= 1'b0;
            mem_addr_r <= {MEM_ADDR_BITS{1'b0}};
        end else begin
            arready_r <= (state_s == ST_IDLE);
            rvalid_r  <= (state_s == ST_RESP);
            rlast_r   <= (state_s == ST_RESP) && (cnt_s == len_s);
            rresp_r   <= err_s ? RESP_SLVERR : RESP_OKAY;
            mem_ce_r  <= (state_s == ST_ADDR) && !err_s;
            if ((state_s == ST_ADDR) && !err_s) begin
                mem_addr_r <= addr_s[MEM_ADDR_BITS+1:2];
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (state_r == ST_WAIT) begin
                rdata_r <= err_r ? 32'd0 : mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign ARREADY_S = arready_r;
    assign RVALID_S  = rvalid_r;
    assign RLAST_S   = rlast_r;
    assign RRESP_S   = rresp_r;
    assign RDATA_S   = rdata_r;
    assign RID_S     = id_r;
    assign mem_ce    = mem_ce_r;
    assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_axi_slave_read_engine.sv
// Directed self-checking bench for axi_slave_read_engine with a small
// SRAM model whose data encodes the word address.
module tb_axi_slave_read_engine;
    import axi_slave_read_engine_pkg::*;

    localparam int MAB = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;
    logic        mem_ce;
    logic [MAB-1:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;

    int tests = 0;
    int fails = 0;
    logic hold_rready = 1'b0;
    logic [MAB-1:0] ce_log[$];
    logic [MAB-1:0] exp_q[$];

    always #5 clk = ~clk;

    axi_slave_read_engine #(.MEM_ADDR_BITS(MAB)) dut (
        .clk(clk), .rst(rst),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
        .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] pat(input logic [MAB-1:0] w);
        return {16'hC0DE, 2'b00, w};
    endfunction

    // SRAM model: one-cycle read latency, every strobe logged
    always @(posedge clk) begin
        if (mem_ce) begin
            mem_rdata <= pat(mem_addr);
            ce_log.push_back(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ce(input string tag);
        chk({tag, "_ce_count"}, 32'(ce_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < ce_log.size()) chk($sformatf("%s_ce%0d", tag, i), 32'(ce_log[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic ar(input logic [7:0] id, input logic [31:0] a, input logic [3:0] l,
                      input logic [2:0] s, input logic [1:0] b);
        @(negedge clk);
        chk("arready_before_ar", 32'(ARREADY_S), 32'd1);
        ARID_S = id; ARADDR_S = a; ARLEN_S = l; ARSIZE_S = s; ARBURST_S = b;
        ARVALID_S = 1'b1;
        @(posedge clk);
        #1 ARVALID_S = 1'b0;
    endtask

    // Count falling edges until RVALID is seen (bounded)
    task automatic wait_rv(output int n);
        bit seen = 1'b0;
        n = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            seen = RVALID_S;
        end
    endtask

    task automatic check_fields(input string tag, input logic [7:0] id, input logic [31:0] data,
                                input logic [1:0] resp, input logic last);
        chk({tag, "_rvalid"}, 32'(RVALID_S), 32'd1);
        chk({tag, "_rdata"},  RDATA_S, data);
        chk({tag, "_rresp"},  32'(RRESP_S), 32'(resp));
        chk({tag, "_rlast"},  32'(RLAST_S), 32'(last));
        chk({tag, "_rid"},    32'(RID_S), 32'(id));
    endtask

    task automatic accept();
        RREADY_S = 1'b1;
        @(posedge clk);
        #1 RREADY_S = hold_rready;
    endtask

    task automatic beat(input string tag, input logic [7:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
        int n;
        wait_rv(n);
        chk({tag, "_latency"}, 32'(n), 32'd3);
        check_fields(tag, id, data, resp, last);
        accept();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int rv_seen;
        rst = 1'b1; ARVALID_S = 1'b0; ARID_S = 8'd0; ARADDR_S = 32'd0;
        ARLEN_S = 4'd0; ARSIZE_S = 3'd0; ARBURST_S = 2'd0; RREADY_S = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(ARREADY_S), 32'd1);
        chk("rst_rvalid",  32'(RVALID_S), 32'd0);
        chk("rst_rlast",   32'(RLAST_S), 32'd0);
        chk("rst_rresp",   32'(RRESP_S), 32'd0);
        chk("rst_rid",     32'(RID_S), 32'd0);
        chk("rst_rdata",   RDATA_S, 32'd0);
        chk("rst_mem_ce",  32'(mem_ce), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        // INCR word burst
        ce_log.delete();
        ar(8'h35, 32'h0000_0010, 4'd3, 3'd2, BURST_INCR);
        for (int i = 0; i < 4; i++) beat($sformatf("incr_b%0d", i), 8'h35, pat(14'(4 + i)), RESP_OKAY, (i == 3));
        exp_q = '{14'd4, 14'd5, 14'd6, 14'd7}; chk_ce("incr");

        // WRAP burst with RREADY held high throughout (early RREADY ignored)
        ce_log.delete();
        hold_rready = 1'b1; RREADY_S = 1'b1;
        ar(8'h42, 32'h0000_0038, 4'd3, 3'd2, BURST_WRAP);
        beat("wrap_b0", 8'h42, pat(14'd14), RESP_OKAY, 1'b0);
        beat("wrap_b1", 8'h42, pat(14'd15), RESP_OKAY, 1'b0);
        beat("wrap_b2", 8'h42, pat(14'd12), RESP_OKAY, 1'b0);
        beat("wrap_b3", 8'h42, pat(14'd13), RESP_OKAY, 1'b1);
        hold_rready = 1'b0; RREADY_S = 1'b0;
        exp_q = '{14'd14, 14'd15, 14'd12, 14'd13}; chk_ce("wrap");

        // Backpressure: RREADY low 5 cycles in RESP
        ce_log.delete();
        ar(8'h11, 32'h0000_0100, 4'd1, 3'd2, BURST_INCR);
        wait_rv(n);
        chk("bp_latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check_fields($sformatf("bp_hold%0d", i), 8'h11, pat(14'h40), RESP_OKAY, 1'b0);
            chk($sformatf("bp_hold%0d_mem_ce", i), 32'(mem_ce), 32'd0);
            @(negedge clk);
        end
        chk("bp_ce_during_hold", 32'(ce_log.size()), 32'd1);
        accept();
        beat("bp_b1", 8'h11, pat(14'h41), RESP_OKAY, 1'b1);
        exp_q = '{14'h40, 14'h41}; chk_ce("bp");

        // Sub-word INCR returns the full aligned word
        ce_log.delete();
        ar(8'h21, 32'h0000_0041, 4'd3, 3'd0, BURST_INCR);
        for (int i = 0; i < 4; i++) beat($sformatf("byte_b%0d", i), 8'h21, pat((i == 3) ? 14'h11 : 14'h10), RESP_OKAY, (i == 3));
        exp_q = '{14'h10, 14'h10, 14'h10, 14'h11}; chk_ce("byte");

        // Last words of the SRAM are still in range
        ce_log.delete();
        ar(8'h22, 32'h0000_FFF8, 4'd1, 3'd2, BURST_INCR);
        beat("top_b0", 8'h22, pat(14'h3FFE), RESP_OKAY, 1'b0);
        beat("top_b1", 8'h22, pat(14'h3FFF), RESP_OKAY, 1'b1);
        exp_q = '{14'h3FFE, 14'h3FFF}; chk_ce("top");

        // Error bursts: none of them may strobe the SRAM
        ce_log.delete();
        exp_q.delete();
        ar(8'h90, 32'h0001_0000, 4'd1, 3'd2, BURST_INCR);
        beat("oor_b0", 8'h90, 32'd0, RESP_SLVERR, 1'b0);
        beat("oor_b1", 8'h90, 32'd0, RESP_SLVERR, 1'b1);
        ar(8'h91, 32'h0000_FFFC, 4'd1, 3'd2, BURST_INCR);
        beat("cross_b0", 8'h91, 32'd0, RESP_SLVERR, 1'b0);
        beat("cross_b1", 8'h91, 32'd0, RESP_SLVERR, 1'b1);
        ar(8'h92, 32'h0000_0000, 4'd0, 3'd2, BURST_RSVD);
        beat("rsvd_b0", 8'h92, 32'd0, RESP_SLVERR, 1'b1);
        ar(8'h93, 32'h0000_0000, 4'd0, 3'd3, BURST_INCR);
        beat("size_b0", 8'h93, 32'd0, RESP_SLVERR, 1'b1);
        ar(8'h94, 32'h0000_0000, 4'd2, 3'd2, BURST_WRAP);
        beat("wlen_b0", 8'h94, 32'd0, RESP_SLVERR, 1'b0);
        beat("wlen_b1", 8'h94, 32'd0, RESP_SLVERR, 1'b0);
        beat("wlen_b2", 8'h94, 32'd0, RESP_SLVERR, 1'b1);
        chk_ce("err");

        // Recovery from error: next good burst is OKAY
        ce_log.delete();
        ar(8'h23, 32'h0000_0024, 4'd2, 3'd2, BURST_FIXED);
        for (int i = 0; i < 3; i++) beat($sformatf("fixed_b%0d", i), 8'h23, pat(14'd9), RESP_OKAY, (i == 2));
        exp_q = '{14'd9, 14'd9, 14'd9}; chk_ce("fixed");

        // Reset during beat 2 of an 8-beat burst
        ce_log.delete();
        ar(8'h50, 32'h0000_0000, 4'd7, 3'd2, BURST_INCR);
        beat("rb_b0", 8'h50, pat(14'd0), RESP_OKAY, 1'b0);
        wait_rv(n);
        chk("rb_b1_latency", 32'(n), 32'd3);
        chk("rb_b1_rdata", RDATA_S, pat(14'd1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rb_rvalid", 32'(RVALID_S), 32'd0);
        chk("rb_arready", 32'(ARREADY_S), 32'd1);
        chk("rb_rdata", RDATA_S, 32'd0);
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (RVALID_S) rv_seen++;
        end
        chk("rb_quiet_rvalid", 32'(rv_seen), 32'd0);
        chk("rb_ce_count", 32'(ce_log.size()), 32'd2);
        ce_log.delete();
        ar(8'h51, 32'h0000_0020, 4'd0, 3'd2, BURST_FIXED);
        beat("rb_next", 8'h51, pat(14'd8), RESP_OKAY, 1'b1);
        exp_q = '{14'd8}; chk_ce("rb_next");

        // Back-to-back: new AR held during the final RESP
        ce_log.delete();
        ar(8'h77, 32'h0000_0200, 4'd1, 3'd2, BURST_INCR);
        beat("b2b_b0", 8'h77, pat(14'h80), RESP_OKAY, 1'b0);
        wait_rv(n);
        chk("b2b_b1_latency", 32'(n), 32'd3);
        check_fields("b2b_b1", 8'h77, pat(14'h81), RESP_OKAY, 1'b1);
        ARID_S = 8'h78; ARADDR_S = 32'h0000_0300; ARLEN_S = 4'd0;
        ARSIZE_S = 3'd2; ARBURST_S = BURST_INCR; ARVALID_S = 1'b1;
        @(negedge clk);
        chk("b2b_arready_in_resp", 32'(ARREADY_S), 32'd0);
        check_fields("b2b_b1_held", 8'h77, pat(14'h81), RESP_OKAY, 1'b1);
        RREADY_S = 1'b1;
        @(posedge clk);
        #1 RREADY_S = 1'b0;
        chk("b2b_arready_after_last", 32'(ARREADY_S), 32'd1);
        chk("b2b_rvalid_after_last", 32'(RVALID_S), 32'd0);
        @(posedge clk);
        #1 ARVALID_S = 1'b0;
        chk("b2b_arready_after_accept", 32'(ARREADY_S), 32'd0);
        beat("b2b_new", 8'h78, pat(14'hC0), RESP_OKAY, 1'b1);
        exp_q = '{14'h80, 14'h81, 14'hC0}; chk_ce("b2b");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_slave_read_engine.md
AXI_SLAVE_READ_ENGINE -- requirements
Module: axi_slave_read_engine

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 14, word-address width of the attached SRAM (64 KiB).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 ARID_S  input  AXI_IDS_BITS (8)  {master[3:0], id[3:0]} tag from the interconnect.
REQ-005 ARADDR_S  input  AXI_ADDR_BITS (32)  byte start address.
REQ-006 ARLEN_S  input  AXI_LEN_BITS (4)  beats minus one.
REQ-007 ARSIZE_S  input  AXI_SIZE_BITS (3)  bytes per beat = 1<<ARSIZE_S.
REQ-008 ARBURST_S  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-009 ARVALID_S input 1 / ARREADY_S output 1  read-address handshake.
REQ-010 RID_S  output  8  echo of the accepted ARID_S.
REQ-011 RDATA_S  output  32  read beat data.
REQ-012 RRESP_S output 2 / RLAST_S output 1  response code / final-beat flag.
REQ-013 RVALID_S output 1 / RREADY_S input 1  read-data handshake toward the read-data mux.
REQ-014 mem_ce output 1 / mem_addr output MEM_ADDR_BITS  SRAM read strobe / word address.
REQ-015 mem_rdata  input  32  SRAM data, valid exactly one cycle after mem_ce.

Function
REQ-016 FSM states: IDLE, ADDR, WAIT, RESP; ARREADY_S SHALL be 1 only in IDLE.
REQ-017 IDLE: on ARVALID_S&ARREADY_S, latch ID/ADDR/LEN/SIZE/BURST, clear beat counter, compute error flag, go ADDR.
REQ-018 ADDR: mem_ce=1 and mem_addr=addr_q[MEM_ADDR_BITS+1:2] unless error flag set (mem_ce=0); go WAIT.
REQ-019 WAIT: capture mem_rdata (or 0 if error) into rdata_q at cycle end; go RESP.
REQ-020 RESP: RVALID_S=1; RDATA_S, RID_S, RRESP_S, RLAST_S stable until RREADY_S sampled high.
REQ-021 RLAST_S SHALL be 1 iff beat counter equals latched LEN.
REQ-022 RESP with RREADY_S=1 and not last: counter+1, addr_q <= next address, go ADDR; with last: go IDLE.
REQ-023 Latency: AR handshake at edge T -> RVALID_S high in cycle T+3; each later beat 3 cycles after prior R handshake.
REQ-024 Next address: FIXED unchanged; INCR addr+(1<<SIZE); WRAP addr+(1<<SIZE) wrapped within aligned block of (LEN+1)<<SIZE bytes.
REQ-025 Error (RRESP=2'b10 SLVERR, RDATA=0, no mem_ce) for whole burst if: ARBURST=11; ARSIZE>2; WRAP with LEN not in {1,3,7,15}; any beat address >= 4<<MEM_ADDR_BITS.
REQ-026 Otherwise RRESP_S=2'b00 OKAY; sub-word sizes return the full aligned 32-bit word.
REQ-027 INCR crossing a 4 KiB boundary is not checked; address arithmetic is 32-bit modulo.
REQ-028 RREADY_S asserted outside RESP SHALL be ignored; ARVALID_S outside IDLE SHALL not be accepted.

Reset
REQ-029 rst sampled high SHALL force IDLE, ARREADY_S=1, RVALID_S=0, RLAST_S=0, RRESP_S=0, RID_S=0, RDATA_S=0, mem_ce=0, mem_addr=0, counter=0.
REQ-030 rst mid-burst SHALL abandon the burst with no further beats; the next AR is serviced normally.

Structure
REQ-031 Widths come from AXI_define.svh; burst and response encodings SHALL live in the shared AXI package; the FSM enum stays local.
REQ-032 Next-address and wrap arithmetic SHALL be one combinational sub-module, axi_burst_addr_gen, shared with the future write engine.
REQ-033 Implementation target 150-300 lines of RTL; no memories inside the block.

Verification
REQ-034 INCR: ARADDR=0x0000_0010, LEN=3, SIZE=2, RREADY=1 -> mem_addr 4,5,6,7; 4 beats OKAY; RLAST on beat 4; RID=ARID.
REQ-035 WRAP: ARADDR=0x38, LEN=3, SIZE=2 -> word addresses 14,15,12,13; RLAST on 4th beat.
REQ-036 Backpressure: RREADY low 5 cycles in RESP -> RVALID and all R fields held constant; no counter advance; no mem_ce.
REQ-037 Error: ARADDR=0x0001_0000 (MEM_ADDR_BITS=14), LEN=1 -> 2 beats RRESP=10, RDATA=0, mem_ce never asserted.
REQ-038 Reset: rst high during beat 2 of LEN=7 -> next cycle RVALID=0, ARREADY=1; following FIXED LEN=0 read completes OKAY.
REQ-039 Back-to-back: ARVALID held high with new request during RESP -> not accepted until cycle after final R handshake.
